// File: rtl/mem_bus_pkg.sv
// Shared definitions for the native memory bus: field widths, arbiter state
// encoding and the default error read word.
package mem_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } bus_req_t;

endpackage

// File: rtl/bus_watchdog.sv
// Cycle counter for a pending bus access; expire flags the last allowed cycle.
// TIMEOUT=0 keeps the counter at zero and never expires.
module bus_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && TIMEOUT != 0)
            count <= count + TW'(1);
    end

    assign expire = (TIMEOUT != 0) && (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the native memory bus with a watchdog
// that terminates accesses the slave never answers.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int                TIMEOUT   = 255,
    parameter int                TW        = 8,
    parameter logic [DATA_W-1:0] ERR_RDATA = ERR_RDATA_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_valid,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_valid,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_valid,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        grant,
    output logic              timeout
);

    arb_state_t state;
    logic       prio;

    bus_req_t [1:0]             req;
    bus_req_t                   cur;
    logic [1:0]                 rsp_ready;
    logic [1:0][DATA_W-1:0]     rsp_rdata;
    logic                       busy, own, wd_expire;
    logic                       fin_ok, fin_to, abort;

    assign req[0] = '{valid: m0_valid, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
    assign req[1] = '{valid: m1_valid, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

    assign busy = (state != IDLE);
    assign own  = (state == GNT1);
    assign cur  = req[own];

    assign fin_ok = busy &  cur.valid &  s_ready;
    assign fin_to = busy &  cur.valid & ~s_ready & wd_expire;
    assign abort  = busy & ~cur.valid;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (~busy | fin_ok | fin_to | abort),
        .en     (busy & ~s_ready),
        .expire (wd_expire)
    );

    // Request fields pass through untouched while granted; the slave never
    // sees valid in the cycle the watchdog fires.
    always_comb begin
        s_valid   = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        rsp_ready = '0;
        rsp_rdata = '0;
        if (busy) begin
            s_valid        = cur.valid & ~fin_to;
            s_addr         = cur.addr;
            s_wdata        = cur.wdata;
            s_wstrb        = cur.wstrb;
            rsp_ready[own] = fin_ok | fin_to;
            rsp_rdata[own] = fin_to ? ERR_RDATA : s_rdata;
        end
    end

    assign m0_ready = rsp_ready[0];
    assign m1_ready = rsp_ready[1];
    assign m0_rdata = rsp_rdata[0];
    assign m1_rdata = rsp_rdata[1];
    assign timeout  = fin_to;
    assign grant    = {state == GNT1, state == GNT0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req[0].valid && req[1].valid)
                        state <= prio ? GNT1 : GNT0;
                    else if (req[0].valid)
                        state <= GNT0;
                    else if (req[1].valid)
                        state <= GNT1;
                end
                default: begin
                    // Abort leaves prio alone so the dropped master is not penalised.
                    if (abort) begin
                        state <= IDLE;
                    end else if (fin_ok) begin
                        state <= IDLE;
                        prio  <= ~own;
                    end else if (fin_to) begin
                        state <= IDLE;
                        prio  <= ~prio;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a cycle-level ownership model.
module tb_mem_arbiter;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_valid, m1_valid, m0_ready, m1_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic        s_valid, s_ready, timeout;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.TIMEOUT(T), .TW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata), .grant(grant), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Master-side request state and reference-model state.
    bit          act [2];
    logic [31:0] ra [2], rd [2];
    logic [3:0]  rs [2];
    int          own, prio, wt;

    task automatic drive();
        m0_valid = act[0]; m0_addr = ra[0]; m0_wdata = rd[0]; m0_wstrb = rs[0];
        m1_valid = act[1]; m1_addr = ra[1]; m1_wdata = rd[1]; m1_wstrb = rs[1];
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " s_valid"}, s_valid, 0);
        chk({tag, " s_bus"}, {s_addr, s_wdata[27:0], s_wstrb}, 0);
        chk({tag, " ready"}, {m0_ready, m1_ready}, 0);
        chk({tag, " rdata"}, {m0_rdata, m1_rdata}, 0);
        chk({tag, " grant"}, grant, 0);
        chk({tag, " timeout"}, timeout, 0);
    endtask

    initial begin
        logic        v, done, to, ev, eto;
        logic [31:0] ea, ed, er [2];
        logic [3:0]  es;
        logic [1:0]  erdy, eg;

        rst_n = 1'b0; s_ready = 1'b0; s_rdata = '0;
        for (int i = 0; i < 2; i++) begin act[i] = 0; ra[i] = '0; rd[i] = '0; rs[i] = '0; end
        drive();
        own = -1; prio = 0; wt = 0;
        repeat (3) @(negedge clk);
        #1 chk_idle("reset");
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc % 613 == 400) begin
                // Asynchronous reset in the middle of whatever is in flight.
                rst_n = 1'b0;
                #1 chk_idle("async_reset");
                act[0] = 0; act[1] = 0; drive();
                own = -1; prio = 0; wt = 0;
                @(negedge clk);
                rst_n = 1'b1;
                continue;
            end
            for (int i = 0; i < 2; i++) begin
                if (!act[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        act[i] = 1;
                        ra[i]  = $urandom;
                        rd[i]  = $urandom;
                        rs[i]  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    act[i] = 0;
                end
            end
            // Periodic stretches of an unresponsive slave exercise the watchdog.
            s_ready = (cyc % 300 < 40) ? 1'b0 : 1'($urandom_range(0, 1));
            s_rdata = $urandom;
            drive();
            #1;

            ev = 0; ea = '0; ed = '0; es = '0; erdy = '0; eg = '0; eto = 0;
            er[0] = '0; er[1] = '0; v = 0; done = 0; to = 0;
            if (own >= 0) begin
                v    = act[own];
                done = v && s_ready;
                to   = v && !s_ready && (wt == T - 1);
                ev   = v && !to;
                ea   = ra[own]; ed = rd[own]; es = rs[own];
                erdy[own] = done || to;
                er[own]   = to ? 32'hDEAD_BEEF : s_rdata;
                eg[own]   = 1'b1;
                eto       = to;
            end
            chk("s_valid", s_valid, ev);
            chk("s_addr", s_addr, ea);
            chk("s_wdata", s_wdata, ed);
            chk("s_wstrb", s_wstrb, es);
            chk("m0_ready", m0_ready, erdy[0]);
            chk("m1_ready", m1_ready, erdy[1]);
            chk("m0_rdata", m0_rdata, er[0]);
            chk("m1_rdata", m1_rdata, er[1]);
            chk("grant", grant, eg);
            chk("timeout", timeout, eto);

            if (own < 0) begin
                if (act[0] && act[1]) own = prio;
                else if (act[0])      own = 0;
                else if (act[1])      own = 1;
                wt = 0;
            end else if (!v) begin
                own = -1; wt = 0;
            end else if (done) begin
                prio = 1 - own; own = -1; wt = 0;
            end else if (to) begin
                prio = 1 - prio; own = -1; wt = 0;
            end else begin
                wt++;
            end
            for (int i = 0; i < 2; i++)
                if (erdy[i]) act[i] = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
